// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline constants for the stall controller: multiply/divide latencies,
// Tuse/Tnew encodings and the per-source hazard comparison.
package pipe_stall_ctrl_pkg;

    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    typedef logic [4:0] reg_idx_t;
    typedef logic [1:0] stage_time_t;

    localparam reg_idx_t    REG_ZERO  = 5'd0;
    // A Tuse of 3 marks an operand the D-stage instruction never reads.
    localparam stage_time_t TUSE_NONE = 2'd3;

    typedef enum logic {
        MD_MULT = 1'b0,
        MD_DIV  = 1'b1
    } md_op_e;

    function automatic int unsigned cnt_width(int unsigned mult_cyc, int unsigned div_cyc);
        int unsigned longest;
        longest = (mult_cyc > div_cyc) ? mult_cyc : div_cyc;
        return $clog2(longest + 1);
    endfunction

    // The producer's value is not ready in time when it arrives later than the consumer needs it.
    function automatic logic src_hazard(reg_idx_t src, stage_time_t tuse,
                                        reg_idx_t dst, stage_time_t tnew);
        return (src != REG_ZERO) && (tuse != TUSE_NONE) && (dst == src) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the stall controller (slave).
interface pipe_stall_ctrl_if;
    import pipe_stall_ctrl_pkg::*;

    reg_idx_t    D_rs;
    reg_idx_t    D_rt;
    stage_time_t D_Tuse_rs;
    stage_time_t D_Tuse_rt;
    reg_idx_t    E_A3;
    reg_idx_t    M_A3;
    stage_time_t E_Tnew;
    stage_time_t M_Tnew;
    logic        D_is_md;
    logic        E_md_start;
    logic        E_md_div;
    logic        F_WE;
    logic        D_WE;
    logic        E_Flush;
    logic        md_busy;
    logic [31:0] stall_cnt;
    logic        md_err;

    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_A3, M_A3, E_Tnew, M_Tnew,
               D_is_md, E_md_start, E_md_div,
        input  F_WE, D_WE, E_Flush, md_busy, stall_cnt, md_err
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_A3, M_A3, E_Tnew, M_Tnew,
               D_is_md, E_md_start, E_md_div,
        output F_WE, D_WE, E_Flush, md_busy, stall_cnt, md_err
    );

endinterface

// File: rtl/pipe_stall_ctrl_md_busy_timer.sv
// HI/LO unit occupancy timer: counts down the multiply/divide latency and flags
// a start that arrives while the unit is still occupied.
module md_busy_timer
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  md_op_e op,
    output logic   busy,
    output logic   err
);

    localparam int unsigned CNT_W = cnt_width(MULT_CYC, DIV_CYC);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; a blocking write here would leak into same-edge readers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (start) begin
                err <= 1'b1;
            end
        end else if (start) begin
            cnt <= (op == MD_DIV) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Decode-stage stall controller: register hazards against E/M producers plus
// HI/LO unit occupancy, with a free-running stall-cycle counter.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    pipe_stall_ctrl_if.slave   bus
);

    logic        stall_rs;
    logic        stall_rt;
    logic        stall_md;
    logic        stall;
    logic        md_busy;
    logic [31:0] stall_cnt;

    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    always_comb begin
        stall_rs = src_hazard(bus.D_rs, bus.D_Tuse_rs, bus.E_A3, bus.E_Tnew) ||
                   src_hazard(bus.D_rs, bus.D_Tuse_rs, bus.M_A3, bus.M_Tnew);
        stall_rt = src_hazard(bus.D_rt, bus.D_Tuse_rt, bus.E_A3, bus.E_Tnew) ||
                   src_hazard(bus.D_rt, bus.D_Tuse_rt, bus.M_A3, bus.M_Tnew);
        // A start in E occupies the unit from the next edge, so D must already wait.
        stall_md = bus.D_is_md && (md_busy || bus.E_md_start);
        stall    = stall_rs || stall_rt || stall_md;
    end

    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_timer (
        .clk   (clk),
        .reset (reset),
        .start (bus.E_md_start),
        .op    (md_op_e'(bus.E_md_div)),
        .busy  (md_busy),
        .err   (bus.md_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.F_WE      = ~stall;
    assign bus.D_WE      = ~stall;
    assign bus.E_Flush   = stall;
    assign bus.md_busy   = md_busy;
    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: inputs change on the falling edge,
// outputs are sampled 1 ns later, well clear of the rising edge.
module tb_pipe_stall_ctrl;
    import pipe_stall_ctrl_pkg::*;

    typedef struct packed {
        logic        f_we;
        logic        d_we;
        logic        e_flush;
        logic        md_busy;
        logic        md_err;
        logic [31:0] stall_cnt;
    } obs_t;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic [4:0] ea3;
        logic [1:0] etnew;
        logic [4:0] ma3;
        logic [1:0] mtnew;
        bit         stall;
    } haz_t;

    logic clk;
    logic reset;
    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_cnt;
    obs_t        exp_q[$];
    obs_t        got;
    obs_t        exp_v;

    function automatic obs_t observe();
        return '{bus.F_WE, bus.D_WE, bus.E_Flush, bus.md_busy, bus.md_err, bus.stall_cnt};
    endfunction

    function automatic obs_t mk(bit stall, bit busy, bit err, logic [31:0] cnt);
        return '{~stall, ~stall, stall, busy, err, cnt};
    endfunction

    task automatic set_idle();
        bus.D_rs       = 5'd0;
        bus.D_rt       = 5'd0;
        bus.D_Tuse_rs  = TUSE_NONE;
        bus.D_Tuse_rt  = TUSE_NONE;
        bus.E_A3       = 5'd0;
        bus.M_A3       = 5'd0;
        bus.E_Tnew     = 2'd0;
        bus.M_Tnew     = 2'd0;
        bus.D_is_md    = 1'b0;
        bus.E_md_start = 1'b0;
        bus.E_md_div   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_idle();
        exp_cnt = 32'd0;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0));
        #3;
        got = observe();
        exp_v = exp_q.pop_front();
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_state got=%h expected=%h", got, exp_v);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic apply_haz(haz_t h);
        bus.D_rs      = h.rs;
        bus.D_rt      = h.rt;
        bus.D_Tuse_rs = h.tuse_rs;
        bus.D_Tuse_rt = h.tuse_rt;
        bus.E_A3      = h.ea3;
        bus.E_Tnew    = h.etnew;
        bus.M_A3      = h.ma3;
        bus.M_Tnew    = h.mtnew;
    endtask

    task automatic test_rs_hazard();
        haz_t tbl [0:4];
        tbl = '{
            '{5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 2'd1, 5'd0, 2'd0, 1'b1},
            '{5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0},
            '{5'd5, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 5'd5, 2'd2, 1'b1},
            '{5'd5, 5'd0, 2'd2, 2'd3, 5'd5, 2'd2, 5'd5, 2'd2, 1'b0},
            '{5'd5, 5'd0, 2'd0, 2'd3, 5'd6, 2'd3, 5'd4, 2'd3, 1'b0}
        };
        do_reset();
        foreach (tbl[i]) begin
            @(negedge clk);
            apply_haz(tbl[i]);
            exp_q.push_back(mk(tbl[i].stall, 1'b0, 1'b0, exp_cnt));
            #1;
            got = observe();
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL rs_hazard[%0d] got=%h expected=%h", i, got, exp_v);
            end
            if (tbl[i].stall) exp_cnt++;
        end
    endtask

    task automatic test_rt_hazard();
        haz_t tbl [0:5];
        tbl = '{
            '{5'd0, 5'd0, 2'd3, 2'd0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0},
            '{5'd0, 5'd0, 2'd3, 2'd0, 5'd0, 2'd0, 5'd0, 2'd3, 1'b0},
            '{5'd0, 5'd7, 2'd3, 2'd1, 5'd0, 2'd0, 5'd7, 2'd2, 1'b1},
            '{5'd0, 5'd7, 2'd3, 2'd2, 5'd0, 2'd0, 5'd7, 2'd2, 1'b0},
            '{5'd0, 5'd7, 2'd3, 2'd3, 5'd7, 2'd3, 5'd7, 2'd3, 1'b0},
            '{5'd0, 5'd9, 2'd3, 2'd0, 5'd9, 2'd1, 5'd0, 2'd0, 1'b1}
        };
        do_reset();
        foreach (tbl[i]) begin
            @(negedge clk);
            apply_haz(tbl[i]);
            exp_q.push_back(mk(tbl[i].stall, 1'b0, 1'b0, exp_cnt));
            #1;
            got = observe();
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL rt_hazard[%0d] got=%h expected=%h", i, got, exp_v);
            end
            if (tbl[i].stall) exp_cnt++;
        end
    endtask

    task automatic test_mult_busy();
        do_reset();
        // Start cycle plus five busy cycles all stall the waiting md instruction.
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(mk(i < 6, (i >= 1) && (i <= 5), 1'b0, exp_cnt));
            if (i < 6) exp_cnt++;
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.D_is_md    = 1'b1;
            bus.E_md_start = (i == 0);
            bus.E_md_div   = 1'b0;
            #1;
            got = observe();
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL mult_busy[%0d] got=%h expected=%h", i, got, exp_v);
            end
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_div_overlap();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(mk(1'b0, (i >= 1) && (i <= 10), i >= 4, exp_cnt));
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.E_md_start = (i == 0) || (i == 3);
            bus.E_md_div   = 1'b1;
            #1;
            got = observe();
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL div_overlap[%0d] got=%h expected=%h", i, got, exp_v);
            end
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.D_is_md    = 1'b1;
            bus.E_md_start = (i == 0);
            bus.E_md_div   = 1'b1;
            exp_q.push_back(mk(1'b1, i >= 1, 1'b0, exp_cnt));
            #1;
            got = observe();
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_mid_div_pre[%0d] got=%h expected=%h", i, got, exp_v);
            end
            exp_cnt++;
        end
        // Counter now holds 7; reset lands between edges and must act immediately.
        #2;
        reset = 1'b1;
        exp_cnt = 32'd0;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, exp_cnt));
        #1;
        got = observe();
        exp_v = exp_q.pop_front();
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_mid_div_async got=%h expected=%h", got, exp_v);
        end
        @(negedge clk);
        reset = 1'b0;
        set_idle();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.E_md_start = (i == 0);
            bus.E_md_div   = 1'b0;
            exp_q.push_back(mk(1'b0, (i >= 1) && (i <= 5), 1'b0, exp_cnt));
            #1;
            got = observe();
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_mid_div_post[%0d] got=%h expected=%h", i, got, exp_v);
            end
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_combined_stall();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                bus.D_rs      = 5'd5;
                bus.D_Tuse_rs = 2'd0;
                bus.E_A3      = 5'd5;
                bus.E_Tnew    = 2'd1;
                bus.D_is_md   = 1'b1;
            end else begin
                set_idle();
            end
            bus.E_md_start = (i == 0);
            bus.E_md_div   = 1'b0;
            exp_q.push_back(mk(i < 4, i >= 1, 1'b0, exp_cnt));
            #1;
            got = observe();
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL combined_stall[%0d] got=%h expected=%h", i, got, exp_v);
            end
            if (i < 4) exp_cnt++;
        end
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_rs_hazard();
        test_rt_hazard();
        test_mult_busy();
        test_div_overlap();
        test_reset_mid_div();
        test_combined_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, busy cycles of a multiply.
REQ-002 SHALL have parameter DIV_CYC, default 10, busy cycles of a divide.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports D_rs, D_rt  input  5 each  source register numbers of the D-stage instruction.
REQ-006 SHALL have ports D_Tuse_rs, D_Tuse_rt  input  2 each  cycles until D-stage instruction consumes rs/rt; 3 = not used.
REQ-007 SHALL have ports E_A3, M_A3  input  5 each  destination registers of the E and M stage instructions; 0 = none.
REQ-008 SHALL have ports E_Tnew, M_Tnew  input  2 each  cycles until E/M result is forwardable.
REQ-009 SHALL have port D_is_md  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port E_md_start  input  1  E-stage instruction is mult/div (one-cycle start).
REQ-011 SHALL have port E_md_div  input  1  qualifies E_md_start: 1 = divide, 0 = multiply.
REQ-012 SHALL have ports F_WE, D_WE  output  1 each  PC and F/D register write enables.
REQ-013 SHALL have port E_Flush  output  1  clears the D/E pipeline register (bubble insert).
REQ-014 SHALL have port md_busy  output  1  HI/LO unit occupied.
REQ-015 SHALL have port stall_cnt  output  32  count of stall cycles since reset.
REQ-016 SHALL have port md_err  output  1  sticky: start while busy.

Function
REQ-017 SHALL assert stall_rs when D_rs!=0 and ((E_A3==D_rs and E_Tnew>D_Tuse_rs) or (M_A3==D_rs and M_Tnew>D_Tuse_rs)); stall_rt likewise with D_rt/D_Tuse_rt.
REQ-018 SHALL assert stall_md when D_is_md and (md_busy or E_md_start).
REQ-019 SHALL compute stall = stall_rs or stall_rt or stall_md combinationally, same cycle, zero latency.
REQ-020 SHALL drive F_WE = D_WE = not stall and E_Flush = stall.
REQ-021 SHALL hold a busy counter cnt (width fits DIV_CYC); md_busy = (cnt != 0).
REQ-022 SHALL load cnt with MULT_CYC (E_md_div=0) or DIV_CYC (E_md_div=1) on a clock where E_md_start=1 and cnt==0.
REQ-023 SHALL decrement cnt by 1 each clock when cnt!=0, terminating at 0 without wrap.
REQ-024 SHALL ignore E_md_start while cnt!=0 (counter continues decrementing) and set md_err, which stays 1 until reset.
REQ-025 SHALL make md_busy high exactly MULT_CYC or DIV_CYC consecutive cycles, starting the cycle after the start edge.
REQ-026 SHALL increment stall_cnt by 1 on each clock edge where stall=1, wrapping 0xFFFFFFFF -> 0.
REQ-027 SHALL treat register 0 as never hazarding, whatever E_A3/M_A3 equal.

Reset
REQ-028 SHALL, while reset=1, asynchronously force cnt=0, md_busy=0, stall_cnt=0, md_err=0.
REQ-029 SHALL leave F_WE, D_WE, E_Flush purely combinational during reset; with idle inputs they read 1,1,0.
REQ-030 SHALL abort an in-flight multiply/divide on reset mid-operation; first post-reset start loads normally.

Structure
REQ-031 SHALL place MULT_CYC/DIV_CYC defaults and Tuse/Tnew encodings (incl. 3 = unused) in the shared pipeline constants package.
REQ-032 SHALL implement the busy counter plus md_err as sub-module md_busy_timer; hazard compare logic stays in the top.

Verification
REQ-033 SHALL test: D_rs=5,D_Tuse_rs=0,E_A3=5,E_Tnew=1 -> F_WE=0,D_WE=0,E_Flush=1 same cycle; E_Tnew=0 -> no stall.
REQ-034 SHALL test: D_rt=0,E_A3=0,E_Tnew=2,D_Tuse_rt=0 -> no stall.
REQ-035 SHALL test: E_md_start=1,E_md_div=0 one cycle -> md_busy=1 for exactly 5 cycles; D_is_md=1 stalls those 5 cycles plus the start cycle; stall_cnt=6.
REQ-036 SHALL test: divide start, second start at busy cycle 3 -> md_err=1, md_busy falls after 10 cycles total from first start.
REQ-037 SHALL test: reset asserted asynchronously mid-divide (cnt=7) -> md_busy=0 and stall_cnt=0 before next clock edge.
REQ-038 SHALL test: rs hazard and md stall simultaneous -> single stall, stall_cnt increments by 1 per cycle.
